// File: rtl/tx_dac_output.sv
// tx_dac_output: gain, mute/unmute envelope ramp, rescale, saturate and format samples for a DW-bit DAC.
module tx_dac_output #(
    parameter int IW            = 16,
    parameter int DW            = 14,
    parameter int GW            = 16,
    parameter int RAMP_LOG2     = 10,
    parameter int OFFSET_BINARY = 1
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic signed [IW-1:0] din,
    input  logic                 din_valid,
    input  logic [GW-1:0]        gain,
    input  logic                 enable,
    input  logic                 clip_clear,
    output logic [DW-1:0]        dac_data,
    output logic                 dac_valid,
    output logic                 clip,
    output logic [15:0]          clip_count,
    output logic [1:0]           state
);
    localparam int PW = IW + GW + 1 - 14;
    localparam int QW = PW + 2;
    localparam int RW = QW - (IW - DW);
    localparam logic [RAMP_LOG2:0] FULL = {1'b1, {RAMP_LOG2{1'b0}}};
    localparam logic [RAMP_LOG2:0] ONE = {{RAMP_LOG2{1'b0}}, 1'b1};
    localparam logic [DW-1:0] ZERO_CODE = {OFFSET_BINARY != 0, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {MUTED, RAMP_UP, ACTIVE, RAMP_DOWN} env_state_t;

    env_state_t fsm, fsm_next;
    logic [RAMP_LOG2:0] env, env_next, env1;
    logic v1, v2;
    logic signed [IW+GW:0] prod1;
    logic signed [PW-1:0] p1;
    logic signed [PW+RAMP_LOG2+1:0] prod2;
    logic signed [QW-1:0] q2;
    logic signed [RW-1:0] r;
    logic sat;
    logic [DW-1:0] code;

    assign state = fsm;
    assign prod1 = din * $signed({1'b0, gain});
    assign prod2 = p1 * $signed({1'b0, env1});
    assign r = RW'(q2 >>> (IW - DW));
    assign sat = r[RW-1:DW-1] != {(RW-DW+1){r[RW-1]}};
    assign code = sat ? {r[RW-1], {(DW-1){~r[RW-1]}}} : r[DW-1:0];

    // A direction change simply reverses the count from the current env, so there is never a jump.
    always_comb begin
        fsm_next = fsm;
        env_next = env;
        if (din_valid) begin
            if (enable) begin
                env_next = (env == FULL) ? env : env + ONE;
                fsm_next = (env_next == FULL) ? ACTIVE : RAMP_UP;
            end else begin
                env_next = (env == '0) ? env : env - ONE;
                fsm_next = (env_next == '0) ? MUTED : RAMP_DOWN;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm        <= MUTED;
            env        <= '0;
            env1       <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            p1         <= '0;
            q2         <= '0;
            dac_valid  <= 1'b0;
            dac_data   <= ZERO_CODE;
            clip       <= 1'b0;
            clip_count <= '0;
        end else begin
            fsm       <= fsm_next;
            env       <= env_next;
            v1        <= din_valid;
            p1        <= PW'(prod1 >>> 14);
            env1      <= env;
            v2        <= v1;
            q2        <= QW'(prod2 >>> RAMP_LOG2);
            dac_valid <= v2;
            if (v2) begin
                dac_data <= code ^ ZERO_CODE;
                clip     <= sat;
            end
            if (clip_clear)
                clip_count <= '0;
            else if (dac_valid && clip && clip_count != 16'hFFFF)
                clip_count <= clip_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_tx_dac_output.sv
// tb_tx_dac_output: directed and randomized checks of tx_dac_output against an arithmetic reference model.
module tb_tx_dac_output;
    logic sys_clk = 1'b0;
    logic rst_n = 1'b1;
    logic signed [15:0] din = '0;
    logic din_valid = 1'b0;
    logic [15:0] gain = '0;
    logic enable = 1'b0;
    logic clip_clear = 1'b0;
    logic [13:0] dac_data;
    logic dac_valid;
    logic clip;
    logic [15:0] clip_count;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit v;
        int code;
        bit clp;
    } ent_t;

    ent_t hist[$];
    int m_env, m_state, m_data, m_count;
    bit m_valid, m_clip;
    bit en_r;

    tx_dac_output #(
        .IW(16), .DW(14), .GW(16), .RAMP_LOG2(4), .OFFSET_BINARY(1)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n(rst_n),
        .din(din),
        .din_valid(din_valid),
        .gain(gain),
        .enable(enable),
        .clip_clear(clip_clear),
        .dac_data(dac_data),
        .dac_valid(dac_valid),
        .clip(clip),
        .clip_count(clip_count),
        .state(state)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic longint floordiv(longint a, longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Output code = floor-scaled product, clamped to 14-bit signed, then shifted to offset binary.
    function automatic ent_t expect_sample(int d, int g, int e);
        ent_t x;
        longint r;
        r = floordiv(floordiv(floordiv(longint'(d) * g, 16384) * e, 16), 4);
        x.v = 1'b1;
        x.clp = (r > 8191) || (r < -8192);
        if (r > 8191) r = 8191;
        if (r < -8192) r = -8192;
        x.code = int'(r) + 8192;
        return x;
    endfunction

    function automatic int rnd_din();
        logic [15:0] u;
        u = 16'($urandom());
        return int'($signed(u));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ent_t z;
        z.v = 1'b0;
        z.code = 0;
        z.clp = 1'b0;
        m_env = 0;
        m_state = 0;
        m_valid = 1'b0;
        m_clip = 1'b0;
        m_data = 'h2000;
        m_count = 0;
        hist.delete();
        hist.push_back(z);
        hist.push_back(z);
    endtask

    task automatic check_all();
        chk("dac_valid", 32'(dac_valid), 32'(m_valid));
        chk("dac_data", 32'(dac_data), 32'(m_data));
        chk("clip", 32'(clip), 32'(m_clip));
        chk("clip_count", 32'(clip_count), 32'(m_count));
        chk("state", 32'(state), 32'(m_state));
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_data", 32'(dac_data), 32'h2000);
        chk("rst_valid", 32'(dac_valid), 32'h0);
        chk("rst_clip", 32'(clip), 32'h0);
        chk("rst_count", 32'(clip_count), 32'h0);
        chk("rst_state", 32'(state), 32'h0);
        @(negedge sys_clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input bit v, input int d, input int g, input bit en, input bit clr, input bit ck);
        ent_t x, o;
        din_valid = v;
        din = 16'(d);
        gain = 16'(g);
        enable = en;
        clip_clear = clr;
        @(posedge sys_clk);
        if (clr) m_count = 0;
        else if (m_valid && m_clip && m_count < 65535) m_count++;
        if (v) x = expect_sample(d, g, m_env);
        else begin
            x.v = 1'b0;
            x.code = 0;
            x.clp = 1'b0;
        end
        hist.push_back(x);
        o = hist.pop_front();
        m_valid = o.v;
        if (o.v) begin
            m_data = o.code;
            m_clip = o.clp;
        end
        if (v) begin
            if (en) begin
                m_env = (m_env < 16) ? m_env + 1 : 16;
                m_state = (m_env == 16) ? 2 : 1;
            end else begin
                m_env = (m_env > 0) ? m_env - 1 : 0;
                m_state = (m_env == 0) ? 0 : 3;
            end
        end
        @(negedge sys_clk);
        if (ck) check_all();
    endtask

    initial begin
        model_reset();
        @(negedge sys_clk);
        do_reset();
        // unmute ramp
        repeat (3) step(1, 'h4000, 'h4000, 0, 0, 1);
        repeat (22) step(1, 'h4000, 'h4000, 1, 0, 1);
        chk("steady_3000", 32'(dac_data), 32'h3000);
        chk("ramp_active", 32'(state), 32'h2);
        // clipping
        repeat (4) step(1, 'h7FFF, 'h8000, 1, 0, 1);
        chk("clip_pos_data", 32'(dac_data), 32'h3FFF);
        chk("clip_pos_flag", 32'(clip), 32'h1);
        repeat (4) step(1, -32768, 'h8000, 1, 0, 1);
        chk("clip_neg_data", 32'(dac_data), 32'h0);
        chk("clip_neg_flag", 32'(clip), 32'h1);
        repeat (3) step(1, -32768, 'h8000, 1, 1, 1);
        chk("clr_wins", 32'(clip_count), 32'h0);
        repeat (4) step(1, 0, 'h4000, 1, 0, 1);
        // random samples while active
        repeat (200) step(1'($urandom_range(0, 1)), rnd_din(), int'($urandom_range(0, 65535)), 1,
                          $urandom_range(0, 15) == 0, 1);
        // mute mid-ramp
        repeat (20) step(1, 'h4000, 'h4000, 0, 0, 1);
        repeat (8) step(1, 'h4000, 'h4000, 1, 0, 1);
        chk("env8_rampup", 32'(state), 32'h1);
        repeat (10) step(1, 'h4000, 'h4000, 0, 0, 1);
        chk("muted_again", 32'(state), 32'h0);
        // valid gaps during ramp up
        for (int i = 0; i < 40; i++) step(i % 2 == 0, 'h4000, 'h4000, 1, 0, 1);
        chk("gap_active", 32'(state), 32'h2);
        repeat (20) step(1, 'h4000, 'h4000, 0, 0, 1);
        // random enable toggles and valid gaps
        en_r = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) en_r = ~en_r;
            step(1'($urandom_range(0, 1)), rnd_din(), int'($urandom_range(0, 65535)), en_r, 1'b0, 1);
        end
        // reset mid-ramp
        repeat (20) step(1, 'h4000, 'h4000, 0, 0, 1);
        repeat (5) step(1, 'h4000, 'h4000, 1, 0, 1);
        do_reset();
        repeat (20) step(1, 'h4000, 'h4000, 1, 0, 1);
        // clip counter saturation
        repeat (16) step(1, 'h7FFF, 'h8000, 1, 0, 1);
        repeat (65540) step(1, 'h7FFF, 'h8000, 1, 0, 0);
        repeat (4) step(1, 'h7FFF, 'h8000, 1, 0, 1);
        chk("count_sat", 32'(clip_count), 32'hFFFF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tx_dac_output.md
# tx_dac_output

Final TX stage between the upconversion channel output and the DAC pins. It applies a programmable digital gain and a click-free mute/unmute envelope ramp to each sample. It then rescales, saturates and formats the result for a DW-bit DAC. Saturation events are reported and counted for the CSR bank.

## Interface

Parameters:
- IW, 16, input sample width (signed two's complement).
- DW, 14, DAC word width.
- GW, 16, gain width; unsigned UQ2.14 format (16384 = 1.0, max ≈ 3.99994).
- RAMP_LOG2, 10, the envelope ramp spans 2^RAMP_LOG2 valid samples.
- OFFSET_BINARY, 1, 1 = offset-binary DAC code (MSB inverted); 0 = two's complement.

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- din  in  IW  signed TX sample (channel output).
- din_valid  in  1  sample qualifier.
- gain  in  GW  UQ2.14 gain, sampled with each valid sample.
- enable  in  1  level; 1 = unmute (ramp up), 0 = mute (ramp down).
- clip_clear  in  1  synchronous clear of clip_count.
- dac_data  out  DW  DAC code.
- dac_valid  out  1  dac_data updated this cycle.
- clip  out  1  the current output sample was saturated (qualified by dac_valid).
- clip_count  out  16  saturating count of clipped samples.
- state  out  2  envelope FSM encoding: 0 MUTED, 1 RAMP_UP, 2 ACTIVE, 3 RAMP_DOWN.

## Operation

- Envelope register env: 0..2^RAMP_LOG2, width RAMP_LOG2+1. It updates only on din_valid cycles.
- FSM (evaluated on din_valid cycles; holds otherwise):
  - MUTED, env=0: enable=1 → RAMP_UP.
  - RAMP_UP: env+1 each valid cycle. At full scale → ACTIVE. enable=0 → RAMP_DOWN, continuing from the current env with no jump.
  - ACTIVE, env=2^RAMP_LOG2: enable=0 → RAMP_DOWN.
  - RAMP_DOWN: env−1 each valid cycle. At 0 → MUTED. enable=1 → RAMP_UP from the current env.
  - A full ramp takes exactly 2^RAMP_LOG2 valid samples.
- A sample valid in cycle t uses env(t) and gain(t), which are the register values during cycle t. env updates at the end of cycle t.
- Arithmetic, full precision, no intermediate overflow:
  - S1: p = din × gain (signed × unsigned, IW+GW+1 bits), then p >>> 14 (arithmetic, floor). env(t) is registered alongside.
  - S2: q = (p × env) >>> RAMP_LOG2.
  - S3: r = q >>> (IW−DW). Saturate r to [−2^(DW−1), 2^(DW−1)−1]. clip = 1 if saturation occurred. If OFFSET_BINARY = 1, invert the MSB.
- clip_count increments on each dac_valid with clip=1 and sticks at 0xFFFF. clip_clear zeroes it; clip_clear wins over a coincident increment.
- When dac_valid=0, dac_data and clip hold their last values.
- Reset is asynchronous and may occur mid-ramp:
  - state=MUTED, env=0, pipeline valids cleared.
  - dac_data = zero code: 2^(DW−1) (0x2000 for DW=14) if OFFSET_BINARY, else 0.
  - dac_valid=0, clip=0, clip_count=0.

## Timing

- Latency: 3 cycles from din_valid to dac_valid (S1, S2, S3 registers). dac_valid is din_valid delayed by 3.
- Throughput: one sample per cycle. Gaps in din_valid propagate as gaps in dac_valid. There is no backpressure.
- A gain or enable change affects the first valid sample presented in or after the cycle of the change.
- The state output changes one cycle after the valid sample that triggers the transition.
- clip_count updates in the cycle after the corresponding dac_valid.

## Test plan

Bench parameters: IW=16, DW=14, RAMP_LOG2=4, OFFSET_BINARY=1.

- **Reset.** Pulse rst_n low asynchronously. Required: dac_data=0x2000, dac_valid=0, clip=0, clip_count=0, state=0.
- **Unmute ramp.** Continuous valid, din=0x4000, gain=0x4000, enable 0→1.
  - The first sample uses env=0 → 0x2000.
  - The k-th output is 0x2000 + 256·k.
  - state=2 after 16 valid samples; steady output 0x3000 (q=0x4000, r=0x1000).
- **Clipping.** In ACTIVE with gain=0x8000:
  - din=0x7FFF → r=0x3FFF saturated → dac_data 0x3FFF, clip=1.
  - din=0x8000 → dac_data 0x0000, clip=1.
  - clip_count increments once per sample. clip_clear asserted with a clipping sample leaves the count at 0.
- **Mute mid-ramp.** Drop enable at env=8 during RAMP_UP. Required: state=3 with env continuing 7, 6, …, 0; outputs decrease by 256 per sample; state=0 after 8 more valid samples.
- **Valid gaps.** Alternate din_valid 1/0 during RAMP_UP. Required:
  - env advances only on valid cycles; the ramp takes 16 valid samples (32 cycles).
  - dac_valid is the 3-cycle-delayed pattern, and dac_data holds during gaps.
- **Reset mid-ramp and count saturation.**
  - Assert rst_n at env=5 → immediate zero code and state=0. After release, the ramp restarts from env=0.
  - Preload 0xFFFE clipped samples. Required: clip_count sticks at 0xFFFF on further clips.
